control_sequencer: RTL and testbench
====================================

# control_sequencer

Multi-cycle control sequencer on the consuming end of the instruction register: it drives the register's load (bus C) and output-enable controls and reads the instruction back off the tristate instruction bus. It decodes each instruction and sequences the three-bus datapath: register file on buses A/B, ALU result on bus C, immediate, program counter and memory. There is exactly one bus-C driver per cycle, and the instruction bus is enabled only while it is sampled.

## Interface
- No parameters; the datapath width is fixed at 32.
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- instrn_data_in  input  32  instruction bus from the instruction register; Z except when ir_instrn_out=1.
- mem_ready  input  1  memory read data is valid on bus C this cycle.
- alu_zero  input  1  ALU result is zero (combinational from ALU).
- ir_busc_in  output  1  instruction register loads bus C at the next clk edge.
- ir_instrn_out  output  1  instruction register drives instrn_data_in.
- mem_rd, pc_out, pc_inc, pc_busc_in  output  1 each  memory read strobe, PC drives memory address, PC+1, PC loads bus C.
- rf_busa_out, rf_busb_out, rf_busc_in  output  1 each  register file: rs1 onto A, rs2 onto B, write bus C into rd.
- rs1_sel, rs2_sel, rd_sel  output  5 each  register addresses.
- alu_op  output  4  ALU function: 0 PASS_A, 1 ADD, 2 SUB, 3 AND, 4 OR.
- alu_busc_out, imm_busb_out, imm_busc_out  output  1 each  bus drive enables.
- imm_data  output  32  zero-extended instr[15:0].
- halted, illegal  output  1 each  HALT reached (level); unknown-opcode pulse (1 cycle).

## Operation
- Instruction fields: opcode=[31:26], rd=[25:21], rs1=[20:16], rs2=[15:11], imm=[15:0].
- Opcodes:
  - 0x00 NOP.
  - 0x01 ADD, 0x02 SUB, 0x03 AND, 0x04 OR: rd ← rs1 op rs2.
  - 0x05 ADDI: rd ← rs1 + imm.
  - 0x06 BEQZ: if rs1==0, PC ← imm.
  - 0x3F HALT.
  - Any other opcode: illegal, executed as NOP.
- Internal 32-bit latched-instruction register (cir). It captures instrn_data_in only at the clk edge ending DECODE; the bus is ignored in every other state.
- All outputs are decoded from the state and cir. Every output not listed as asserted in a state is 0.
- States and transitions:
  - IDLE: all outputs 0. → FETCH.
  - FETCH: mem_rd=1, pc_out=1. Stays while mem_ready=0; → LOAD when mem_ready=1.
  - LOAD: ir_busc_in=1, pc_inc=1; memory holds data on bus C. → DECODE.
  - DECODE: ir_instrn_out=1, cir captured.
    - HALT → HALT.
    - NOP or illegal → FETCH; illegal additionally pulses illegal=1 in the following FETCH cycle.
    - All others → EXEC.
  - EXEC:
    - Common: rf_busa_out=1, rs1_sel=cir.rs1.
    - ALU ops: rf_busb_out=1, rs2_sel=rs2, alu_op per opcode, alu_busc_out=1, rf_busc_in=1, rd_sel=rd. → FETCH.
    - ADDI: imm_busb_out=1 instead of rf_busb_out, alu_op=ADD. → FETCH.
    - BEQZ: alu_op=PASS_A, no bus-C driver. alu_zero=1 → JUMP; otherwise → FETCH.
  - JUMP: imm_busc_out=1, pc_busc_in=1. → FETCH.
  - HALT: halted=1. Stays until rst.
- Invariants, each checked every cycle:
  - At most one of {memory (LOAD), alu_busc_out, imm_busc_out} drives bus C.
  - ir_instrn_out and ir_busc_in are never asserted together.

## Timing
- rst asserted at any time, including mid-FETCH or mid-EXEC: state goes immediately to IDLE, cir clears to 0, and all outputs go to 0 combinationally without waiting for clk.
- First FETCH is one cycle after rst deasserts (the IDLE cycle).
- Latency with a zero-wait memory (mem_ready=1 in the first FETCH cycle):
  - ALU, ADDI, not-taken BEQZ: 4 cycles (FETCH, LOAD, DECODE, EXEC).
  - Taken BEQZ: 5 cycles.
  - NOP and illegal: 3 cycles.
- Each cycle mem_ready stays 0 in FETCH adds one cycle; mem_ready is ignored outside FETCH.
- Register-file write and PC load happen at the clk edge ending EXEC or JUMP. The next FETCH observes the updated PC.
- alu_zero is sampled only at the edge ending EXEC of a BEQZ.

## Test plan
- Reset and no-wait memory:
  - Stimulus: rst pulsed mid-EXEC; after release, mem_ready=1 and memory returns ADD r3,r1,r2 (0x04611000).
  - Response: outputs 0 during rst, one IDLE cycle, then FETCH.
  - Response in EXEC: rs1_sel=1, rs2_sel=2, rd_sel=3, alu_op=1, rf_busc_in=1; next FETCH 4 cycles after the first FETCH.
- Wait states: mem_ready held 0 for 3 cycles → FETCH lasts 4 cycles, ir_busc_in asserted exactly once.
- ADDI r5,r0,0x1234 (0x14A01234) → EXEC has imm_busb_out=1, imm_data=0x00001234, rd_sel=5, rf_busb_out=0.
- BEQZ r1,0x0040 (0x18010040):
  - alu_zero=1 → JUMP with imm_busc_out=1, pc_busc_in=1, imm_data=0x40.
  - alu_zero=0 → FETCH directly after EXEC.
- Illegal opcode 0x10 → no EXEC, illegal=1 for exactly 1 cycle. HALT (0xFC000000) → halted=1 held, no mem_rd until rst.
- Whole run: bench asserts the bus-C single-driver and IR-enable exclusion invariants on every cycle of a mixed 20-instruction program.

Source files
------------

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetches through the instruction register, decodes,
// and drives one bus-C source per cycle for the three-bus datapath.
module control_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instrn_data_in,
  input  logic        mem_ready,
  input  logic        alu_zero,
  output logic        ir_busc_in,
  output logic        ir_instrn_out,
  output logic        mem_rd,
  output logic        pc_out,
  output logic        pc_inc,
  output logic        pc_busc_in,
  output logic        rf_busa_out,
  output logic        rf_busb_out,
  output logic        rf_busc_in,
  output logic [4:0]  rs1_sel,
  output logic [4:0]  rs2_sel,
  output logic [4:0]  rd_sel,
  output logic [3:0]  alu_op,
  output logic        alu_busc_out,
  output logic        imm_busb_out,
  output logic        imm_busc_out,
  output logic [31:0] imm_data,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_DECODE, S_EXEC, S_JUMP, S_HALT
  } state_t;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h05;
  localparam logic [5:0] OP_BEQZ = 6'h06;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [3:0] ALU_PASS_A = 4'd0;
  localparam logic [3:0] ALU_ADD    = 4'd1;

  state_t      state_reg, state_next;
  logic [31:0] cir_reg;
  logic        illegal_reg, illegal_next;
  logic [5:0]  bus_op, cir_op;

  assign bus_op = instrn_data_in[31:26];
  assign cir_op = cir_reg[31:26];

  function automatic logic is_alu(input logic [5:0] op);
    return (op >= OP_ADD) && (op <= OP_OR);
  endfunction

  function automatic logic is_known(input logic [5:0] op);
    return (op == OP_NOP) || is_alu(op) || (op == OP_ADDI) ||
           (op == OP_BEQZ) || (op == OP_HALT);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      cir_reg     <= 32'd0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= illegal_next;
      if (state_reg == S_DECODE) begin
        cir_reg <= instrn_data_in;
      end
    end
  end

  // An illegal opcode leaves DECODE straight for FETCH, so the flag lines up
  // with exactly the first FETCH cycle and clears on the following edge.
  assign illegal_next = (state_reg == S_DECODE) && !is_known(bus_op);
  assign illegal      = illegal_reg;

  always_comb begin
    state_next    = state_reg;
    ir_busc_in    = 1'b0;
    ir_instrn_out = 1'b0;
    mem_rd        = 1'b0;
    pc_out        = 1'b0;
    pc_inc        = 1'b0;
    pc_busc_in    = 1'b0;
    rf_busa_out   = 1'b0;
    rf_busb_out   = 1'b0;
    rf_busc_in    = 1'b0;
    rs1_sel       = 5'd0;
    rs2_sel       = 5'd0;
    rd_sel        = 5'd0;
    alu_op        = ALU_PASS_A;
    alu_busc_out  = 1'b0;
    imm_busb_out  = 1'b0;
    imm_busc_out  = 1'b0;
    imm_data      = 32'd0;
    halted        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        state_next = S_FETCH;
      end
      S_FETCH: begin
        mem_rd = 1'b1;
        pc_out = 1'b1;
        if (mem_ready) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        ir_busc_in = 1'b1;
        pc_inc     = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        // cir is only valid after this edge, so branch on the live bus value.
        ir_instrn_out = 1'b1;
        if (bus_op == OP_HALT) begin
          state_next = S_HALT;
        end else if (is_alu(bus_op) || bus_op == OP_ADDI || bus_op == OP_BEQZ) begin
          state_next = S_EXEC;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_EXEC: begin
        rf_busa_out = 1'b1;
        rs1_sel     = cir_reg[20:16];
        state_next  = S_FETCH;
        if (is_alu(cir_op)) begin
          rf_busb_out  = 1'b1;
          rs2_sel      = cir_reg[15:11];
          alu_op       = cir_op[3:0];
          alu_busc_out = 1'b1;
          rf_busc_in   = 1'b1;
          rd_sel       = cir_reg[25:21];
        end else if (cir_op == OP_ADDI) begin
          imm_busb_out = 1'b1;
          imm_data     = {16'd0, cir_reg[15:0]};
          alu_op       = ALU_ADD;
          alu_busc_out = 1'b1;
          rf_busc_in   = 1'b1;
          rd_sel       = cir_reg[25:21];
        end else if (cir_op == OP_BEQZ) begin
          alu_op = ALU_PASS_A;
          if (alu_zero) begin
            state_next = S_JUMP;
          end
        end
      end
      S_JUMP: begin
        imm_busc_out = 1'b1;
        pc_busc_in   = 1'b1;
        imm_data     = {16'd0, cir_reg[15:0]};
        state_next   = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: models the instruction register and memory
// handshake, checks latency, decode fields and bus invariants.
module tb_control_sequencer;

  logic        clk, rst, mem_ready, alu_zero;
  wire  [31:0] instrn_data_in;
  logic        ir_busc_in, ir_instrn_out, mem_rd, pc_out, pc_inc, pc_busc_in;
  logic        rf_busa_out, rf_busb_out, rf_busc_in;
  logic [4:0]  rs1_sel, rs2_sel, rd_sel;
  logic [3:0]  alu_op;
  logic        alu_busc_out, imm_busb_out, imm_busc_out, halted, illegal;
  logic [31:0] imm_data;

  control_sequencer dut (
    .clk(clk), .rst(rst), .instrn_data_in(instrn_data_in), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .ir_busc_in(ir_busc_in), .ir_instrn_out(ir_instrn_out),
    .mem_rd(mem_rd), .pc_out(pc_out), .pc_inc(pc_inc), .pc_busc_in(pc_busc_in),
    .rf_busa_out(rf_busa_out), .rf_busb_out(rf_busb_out), .rf_busc_in(rf_busc_in),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .rd_sel(rd_sel), .alu_op(alu_op),
    .alu_busc_out(alu_busc_out), .imm_busb_out(imm_busb_out),
    .imm_busc_out(imm_busc_out), .imm_data(imm_data), .halted(halted), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction register model: loads the memory word on ir_busc_in.
  logic [31:0] mem_word = 32'd0;
  logic [31:0] ir_q = 32'd0;
  always @(posedge clk) if (ir_busc_in) ir_q <= mem_word;
  assign instrn_data_in = ir_instrn_out ? ir_q : 32'bz;

  logic [64:0] outs;
  assign outs = {ir_busc_in, ir_instrn_out, mem_rd, pc_out, pc_inc, pc_busc_in,
                 rf_busa_out, rf_busb_out, rf_busc_in, alu_busc_out, imm_busb_out,
                 imm_busc_out, halted, illegal, rs1_sel, rs2_sel, rd_sel, alu_op, imm_data};

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("busc_single", 96'((32'(ir_busc_in) + 32'(alu_busc_out) + 32'(imm_busc_out)) <= 32'd1), 96'd1);
    chk("ir_excl", 96'(ir_busc_in & ir_instrn_out), 96'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observations from the last do_instr call.
  int          cycles, n_irload, n_illegal, n_exec, n_jump;
  logic        got_halt;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu;
  logic        ex_rfb, ex_immb, ex_alubc, ex_rfc, jp_immc, jp_pcl;
  logic [31:0] ex_imm, jp_imm;

  // Runs one instruction from a FETCH sample point to the next FETCH (or HALT).
  task automatic do_instr(input logic [31:0] word, input int waits, input logic zero);
    int  fw;
    bit  done;
    mem_word = word;
    cycles = 0; n_irload = 0; n_illegal = 0; n_exec = 0; n_jump = 0; got_halt = 1'b0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_alu = 0; ex_rfb = 0; ex_immb = 0;
    ex_alubc = 0; ex_rfc = 0; ex_imm = 0; jp_immc = 0; jp_pcl = 0; jp_imm = 0;
    fw = 0; done = 0;
    while (!done && cycles < 60) begin
      if (cycles > 0 && illegal) n_illegal++;
      if (ir_busc_in) n_irload++;
      if (rf_busa_out) begin
        n_exec++;
        ex_rs1 = rs1_sel; ex_rs2 = rs2_sel; ex_rd = rd_sel; ex_alu = alu_op;
        ex_rfb = rf_busb_out; ex_immb = imm_busb_out; ex_alubc = alu_busc_out;
        ex_rfc = rf_busc_in; ex_imm = imm_data;
      end
      if (imm_busc_out) begin
        n_jump++;
        jp_immc = imm_busc_out; jp_pcl = pc_busc_in; jp_imm = imm_data;
      end
      if (halted) begin
        got_halt = 1'b1;
        done = 1;
      end else if (cycles > 0 && mem_rd && n_irload > 0) begin
        done = 1;
      end else begin
        mem_ready = mem_rd && (fw >= waits);
        if (mem_rd) fw++;
        alu_zero = rf_busa_out ? zero : 1'b0;
        tick();
        cycles++;
      end
    end
    mem_ready = 1'b0;
    alu_zero  = 1'b0;
    chk("completion", 96'(done), 96'd1);
  endtask

  function automatic int exp_cycles(input logic [31:0] w, input logic zero, input int waits);
    logic [5:0] op = w[31:26];
    if (op >= 6'h01 && op <= 6'h05) return 4 + waits;
    if (op == 6'h06) return (zero ? 5 : 4) + waits;
    return 3 + waits;
  endfunction

  function automatic logic [3:0] exp_alu(input logic [31:0] w);
    logic [5:0] op = w[31:26];
    if (op >= 6'h01 && op <= 6'h04) return op[3:0];
    if (op == 6'h05) return 4'd1;
    return 4'd0;
  endfunction

  function automatic logic [4:0] exp_rd(input logic [31:0] w);
    logic [5:0] op = w[31:26];
    if (op >= 6'h01 && op <= 6'h05) return w[25:21];
    return 5'd0;
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  localparam logic [31:0] W_ADD  = 32'h04611000;
  localparam logic [31:0] W_ADDI = 32'h14A01234;
  localparam logic [31:0] W_BEQZ = 32'h18010040;
  localparam logic [31:0] W_ILL  = 32'h40000000;
  localparam logic [31:0] W_HALT = 32'hFC000000;

  initial begin
    logic [31:0] prog [20];
    rst = 1'b1; mem_ready = 1'b0; alu_zero = 1'b0;
    repeat (3) tick();
    chk("reset_outs", 96'(outs), 96'd0);

    rst = 1'b0;
    chk("idle_outs", 96'(outs), 96'd0);
    tick();
    chk("first_fetch", 96'({mem_rd, pc_out, pc_inc, ir_busc_in}), 96'(4'b1100));

    // Drive ADD into EXEC, then reset asynchronously mid-cycle.
    mem_word = W_ADD; mem_ready = 1'b1;
    tick(); mem_ready = 1'b0;
    chk("load_ctrl", 96'({ir_busc_in, pc_inc, mem_rd}), 96'(3'b110));
    tick();
    chk("decode_oe", 96'({ir_instrn_out, ir_busc_in}), 96'(2'b10));
    tick();
    chk("pre_rst_exec", 96'({rf_busa_out, rd_sel}), 96'({1'b1, 5'd3}));
    #3 rst = 1'b1;
    #1 chk("rst_mid_exec", 96'(outs), 96'd0);
    tick();
    rst = 1'b0;
    chk("idle_after_rst", 96'(outs), 96'd0);
    tick();
    chk("fetch_after_rst", 96'({mem_rd, pc_out}), 96'(2'b11));

    do_instr(W_ADD, 0, 1'b0);
    $display("ADD  r3,r1,r2 cycles=%0d rs1=%0d rs2=%0d rd=%0d op=%0d", cycles, ex_rs1, ex_rs2, ex_rd, ex_alu);
    chk("add_cycles", 96'(cycles), 96'd4);
    chk("add_sel", 96'({ex_rs1, ex_rs2, ex_rd}), 96'({5'd1, 5'd2, 5'd3}));
    chk("add_ctrl", 96'({ex_alu, ex_rfc, ex_alubc, ex_rfb, ex_immb}), 96'({4'd1, 4'b1110}));

    do_instr(W_ADD, 3, 1'b0);
    $display("ADD  wait=3 cycles=%0d irloads=%0d", cycles, n_irload);
    chk("wait_cycles", 96'(cycles), 96'd7);
    chk("wait_irload", 96'(n_irload), 96'd1);

    do_instr(W_ADDI, 0, 1'b0);
    $display("ADDI r5,r0,0x1234 cycles=%0d imm=%h rd=%0d", cycles, ex_imm, ex_rd);
    chk("addi_cycles", 96'(cycles), 96'd4);
    chk("addi_ctrl", 96'({ex_immb, ex_rfb, ex_alubc, ex_rfc, ex_alu}), 96'({4'b1011, 4'd1}));
    chk("addi_imm", 96'(ex_imm), 96'h1234);
    chk("addi_rd", 96'(ex_rd), 96'd5);

    do_instr(W_BEQZ, 0, 1'b1);
    $display("BEQZ taken cycles=%0d jumps=%0d imm=%h", cycles, n_jump, jp_imm);
    chk("beqz_t_cycles", 96'(cycles), 96'd5);
    chk("beqz_t_jump", 96'({n_jump[3:0], jp_immc, jp_pcl}), 96'({4'd1, 2'b11}));
    chk("beqz_t_imm", 96'(jp_imm), 96'h40);
    chk("beqz_exec", 96'({ex_rs1, ex_alu, ex_alubc, ex_rfc}), 96'({5'd1, 4'd0, 2'b00}));

    do_instr(W_BEQZ, 0, 1'b0);
    $display("BEQZ not taken cycles=%0d jumps=%0d", cycles, n_jump);
    chk("beqz_nt_cycles", 96'(cycles), 96'd4);
    chk("beqz_nt_jump", 96'(n_jump), 96'd0);

    do_instr(W_ILL, 0, 1'b0);
    $display("ILL  op=0x10 cycles=%0d execs=%0d illegal_pulses=%0d", cycles, n_exec, n_illegal);
    chk("ill_cycles", 96'(cycles), 96'd3);
    chk("ill_noexec", 96'(n_exec), 96'd0);
    chk("ill_pulse", 96'(n_illegal), 96'd1);

    do_instr(32'd0, 2, 1'b0);
    $display("NOP  wait=2 cycles=%0d illegal_pulses=%0d", cycles, n_illegal);
    chk("nop_cycles", 96'(cycles), 96'd5);
    chk("ill_once", 96'(n_illegal), 96'd0);

    prog[0]  = enc_r(6'h01, 5'd3, 5'd1, 5'd2);    prog[1]  = enc_r(6'h02, 5'd4, 5'd3, 5'd1);
    prog[2]  = enc_r(6'h03, 5'd5, 5'd4, 5'd2);    prog[3]  = enc_r(6'h04, 5'd6, 5'd5, 5'd3);
    prog[4]  = enc_i(6'h05, 5'd7, 5'd0, 16'h00FF); prog[5]  = enc_i(6'h06, 5'd0, 5'd7, 16'h0010);
    prog[6]  = 32'd0;                              prog[7]  = enc_i(6'h06, 5'd0, 5'd2, 16'h0020);
    prog[8]  = {6'h22, 26'd0};                     prog[9]  = enc_r(6'h01, 5'd31, 5'd30, 5'd29);
    prog[10] = enc_r(6'h04, 5'd1, 5'd2, 5'd3);     prog[11] = enc_i(6'h05, 5'd2, 5'd2, 16'hFFFF);
    prog[12] = {6'h3E, 26'd5};                     prog[13] = enc_r(6'h03, 5'd8, 5'd9, 5'd10);
    prog[14] = enc_i(6'h06, 5'd0, 5'd0, 16'h0000); prog[15] = enc_r(6'h02, 5'd12, 5'd11, 5'd10);
    prog[16] = 32'd0;                              prog[17] = enc_i(6'h05, 5'd20, 5'd21, 16'h8000);
    prog[18] = enc_r(6'h01, 5'd0, 5'd0, 5'd0);     prog[19] = enc_i(6'h06, 5'd0, 5'd5, 16'h1234);

    for (int i = 0; i < 20; i++) begin
      do_instr(prog[i], i % 3, 1'(i % 2));
      $display("prog[%0d] word=%h wait=%0d cycles=%0d alu_op=%0d rd=%0d", i, prog[i], i % 3, cycles, ex_alu, ex_rd);
      chk("prog_cycles", 96'(cycles), 96'(exp_cycles(prog[i], 1'(i % 2), i % 3)));
      chk("prog_alu_op", 96'(ex_alu), 96'(exp_alu(prog[i])));
      chk("prog_rd", 96'(ex_rd), 96'(exp_rd(prog[i])));
      chk("prog_irload", 96'(n_irload), 96'd1);
    end

    do_instr(W_HALT, 0, 1'b0);
    $display("HALT cycles=%0d halted=%0b", cycles, got_halt);
    chk("halt_reached", 96'(got_halt), 96'd1);
    chk("halt_cycles", 96'(cycles), 96'd3);
    mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("halt_hold", 96'({halted, mem_rd}), 96'(2'b10));
    end
    mem_ready = 1'b0;
    #2 rst = 1'b1;
    #1 chk("halt_rst", 96'(outs), 96'd0);
    tick();
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
